mips_cpu_muldiv: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/mips_cpu_muldiv.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// It executes MULT/MULTU/DIV/DIVU with a radix-2 iterative datapath. Multiply is
// shift-add and divide is restoring. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only in IDLE/DONE
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a      : rs operand (multiplicand / dividend / MTHI,MTLO data)
//   b      : rt operand (multiplier / divisor)
//   flush  : abort the in-flight operation; HI/LO keep their old values
//   busy   : high while CALC or FIX is active
//   done   : one-cycle pulse when HI/LO take a mult/div result
//   hi, lo : HI/LO registers (product high/low, or remainder/quotient)

module mips_cpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    // Two's-complement negate when neg is set; also used to take magnitudes.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        cond_neg = neg ? (~v + WIDTH'(1)) : v;
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_hi_r;    // running product high half / partial remainder
    logic [WIDTH-1:0]   acc_lo_r;    // multiplier being consumed / dividend->quotient
    logic [WIDTH-1:0]   opd_r;       // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   a_raw_r;     // raw dividend, needed for the divide-by-zero result
    logic               is_div_r;
    logic               neg_q_r;     // negate product / quotient
    logic               neg_r_r;     // negate remainder
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               idle_like_s;
    logic               req_s;
    logic               accept_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic               signed_op_s;
    logic               sa_s;
    logic               sb_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     r_sh_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [WIDTH-1:0]   calc_hi_s;
    logic [WIDTH-1:0]   calc_lo_s;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // DONE accepts requests exactly like IDLE; flush masks any request that cycle.
    assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign req_s       = idle_like_s && start && !flush;
    assign accept_s    = req_s && !op[2];
    assign mthi_s      = req_s && (op == OP_MTHI);
    assign mtlo_s      = req_s && (op == OP_MTLO);

    // MULT and DIV (even opcodes) are the signed variants.
    assign signed_op_s = !op[0];
    assign sa_s        = signed_op_s && a[WIDTH-1];
    assign sb_s        = signed_op_s && b[WIDTH-1];

    // Shift-add step: conditionally add the multiplicand, then shift {carry,hi,lo} right.
    assign mul_sum_s = {1'b0, acc_hi_r} + {1'b0, (acc_lo_r[0] ? opd_r : {WIDTH{1'b0}})};

    // Restoring step: bring in the next dividend bit and try to subtract the divisor.
    // When the shifted remainder overflows into bit WIDTH it is always >= divisor, and
    // the true difference still fits in WIDTH bits, so the wrapped subtract is exact.
    assign r_sh_s     = {acc_hi_r, acc_lo_r[WIDTH-1]};
    assign div_ge_s   = r_sh_s[WIDTH] || (r_sh_s[WIDTH-1:0] >= opd_r);
    assign div_diff_s = r_sh_s[WIDTH-1:0] - opd_r;

    // Next accumulator values for one CALC iteration.
    always_comb begin
        calc_hi_s = acc_hi_r;
        calc_lo_s = acc_lo_r;
        if (is_div_r) begin
            calc_hi_s = div_ge_s ? div_diff_s : r_sh_s[WIDTH-1:0];
            calc_lo_s = {acc_lo_r[WIDTH-2:0], div_ge_s};
        end else begin
            calc_hi_s = mul_sum_s[WIDTH:1];
            calc_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    assign prod_s     = {acc_hi_r, acc_lo_r};
    assign prod_fix_s = neg_q_r ? (~prod_s + (2*WIDTH)'(1)) : prod_s;

    // Sign correction applied in FIX; divide by zero returns all-ones / raw dividend.
    always_comb begin
        fix_hi_s = acc_hi_r;
        fix_lo_s = acc_lo_r;
        if (!is_div_r) begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end else if (div_zero_r) begin
            fix_hi_s = a_raw_r;
            fix_lo_s = {WIDTH{1'b1}};
        end else begin
            fix_hi_s = cond_neg(acc_hi_r, neg_r_r);
            fix_lo_s = cond_neg(acc_lo_r, neg_q_r);
        end
    end

    // FSM next-state: flush wins over everything while an op is in flight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, status flags, operand latch, iteration and HI/LO updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            opd_r      <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FIX);
            done_r  <= (state_r == ST_FIX) && !flush;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        cnt_r      <= CNT_W'(WIDTH);
                        acc_hi_r   <= {WIDTH{1'b0}};
                        acc_lo_r   <= cond_neg(a, sa_s);
                        opd_r      <= cond_neg(b, sb_s);
                        a_raw_r    <= a;
                        is_div_r   <= op[1];
                        neg_q_r    <= sa_s ^ sb_s;
                        neg_r_r    <= sa_s;
                        div_zero_r <= op[1] && (b == {WIDTH{1'b0}});
                    end else if (mthi_s) begin
                        hi_r <= a;
                    end else if (mtlo_s) begin
                        lo_r <= a;
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        acc_hi_r <= calc_hi_s;
                        acc_lo_r <= calc_lo_s;
                        cnt_r    <= cnt_r - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv
// Directed-vector bench for mips_cpu_muldiv. A 32-bit instance covers the main
// operations, sign handling, divide corner cases, MTHI/MTLO, start-while-busy,
// start in DONE, flush and asynchronous reset. An 8-bit instance covers the
// WIDTH parameter. Expected values are hand-computed constants.

module tb_mips_cpu_muldiv;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          flush;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    logic          start8;
    logic [2:0]    op8;
    logic [W8-1:0] a8;
    logic [W8-1:0] b8;
    logic          flush8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] hi8;
    logic [W8-1:0] lo8;

    int n_vec;
    int n_bad;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mips_cpu_muldiv #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current negedge; it is taken at the next rising edge.
    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = b;
    endtask

    // Follows a launched op until done; k counts rising edges from the accepting edge (k=1).
    // Optionally pulses a second start at negedge inj_k (must be ignored while busy).
    task automatic finish_op(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el,
                             input int inj_k);
        int k_hit;
        k_hit = 0;
        for (int k = 1; k <= 80 && k_hit == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check_eq({tag, "/busy_k1"}, busy, 1);
                check_eq({tag, "/done_k1"}, done, 0);
            end
            if (inj_k != 0 && k == inj_k) begin
                launch(3'd1, 32'd3, 32'd3);
            end
            if (inj_k != 0 && k == inj_k + 1) begin
                start = 1'b0;
            end
            if (done) begin
                k_hit = k;
            end
        end
        check_eq({tag, "/latency"}, k_hit, W + 2);
        check_eq({tag, "/busy_at_done"}, busy, 0);
        check_eq({tag, "/hi"}, hi, eh);
        check_eq({tag, "/lo"}, lo, el);
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        check_eq({tag, "/done_pulse"}, done, 0);
        check_eq({tag, "/idle"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        @(negedge clk);
        launch(op, a, b);
        finish_op(tag, eh, el, 0);
        settle(tag);
    endtask

    task automatic run8(input string tag, input logic [2:0] op, input logic [W8-1:0] a,
                        input logic [W8-1:0] b, input logic [W8-1:0] eh, input logic [W8-1:0] el);
        int k_hit;
        k_hit = 0;
        @(negedge clk);
        start8 = 1'b1;
        op8    = op;
        a8     = a;
        b8     = b;
        for (int k = 1; k <= 40 && k_hit == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start8 = 1'b0;
            end
            if (done8) begin
                k_hit = k;
            end
        end
        check_eq({tag, "/latency"}, k_hit, W8 + 2);
        check_eq({tag, "/hi"}, hi8, eh);
        check_eq({tag, "/lo"}, lo8, el);
    endtask

    initial begin
        int dcnt;
        n_vec  = 0;
        n_bad  = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op_i   = 3'd0;
        a_i    = 32'd0;
        b_i    = 32'd0;
        flush  = 1'b0;
        start8 = 1'b0;
        op8    = 3'd0;
        a8     = 8'd0;
        b8     = 8'd0;
        flush8 = 1'b0;

        #12;
        check_eq("reset/busy", busy, 0);
        check_eq("reset/done", done, 0);
        check_eq("reset/hi", hi, 0);
        check_eq("reset/lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_zero",  3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_negb",  3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        // New op accepted in the DONE cycle of the previous one.
        @(negedge clk);
        launch(3'd1, 32'h1234_5678, 32'h10);
        finish_op("multu_a", 32'h0000_0001, 32'h2345_6780, 0);
        launch(3'd0, 32'h8000_0000, 32'd2);
        finish_op("mult_chain", 32'hFFFF_FFFF, 32'h0000_0000, 0);
        settle("mult_chain");

        // MTHI then MTLO back to back.
        @(negedge clk);
        launch(3'd4, 32'h1234, 32'd0);
        @(negedge clk);
        check_eq("mthi/hi", hi, 32'h1234);
        check_eq("mthi/busy", busy, 0);
        launch(3'd5, 32'h5678, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("mtlo/hi", hi, 32'h1234);
        check_eq("mtlo/lo", lo, 32'h5678);
        check_eq("mtlo/busy", busy, 0);
        check_eq("mtlo/done", done, 0);

        // Flush beats start in IDLE.
        launch(3'd4, 32'hDEAD, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_eq("flush_idle/hi", hi, 32'h1234);

        // Reserved opcode is a no-op.
        launch(3'd6, 32'hBEEF, 32'hBEEF);
        @(negedge clk);
        start = 1'b0;
        check_eq("rsvd/busy", busy, 0);
        check_eq("rsvd/hi", hi, 32'h1234);
        check_eq("rsvd/lo", lo, 32'h5678);

        // Second start while busy is ignored.
        @(negedge clk);
        launch(3'd3, 32'd50, 32'd7);
        finish_op("divu_inj", 32'd1, 32'd7, 5);
        settle("divu_inj");

        // Flush mid-CALC: no done, HI/LO untouched.
        @(negedge clk);
        launch(3'd1, 32'd5, 32'd5);
        dcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dcnt++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush/busy", busy, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_eq("flush/done_cnt", dcnt, 0);
        check_eq("flush/hi", hi, 32'd1);
        check_eq("flush/lo", lo, 32'd7);

        // Narrow instance.
        run8("w8_multu", 3'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8("w8_div_ovf", 3'd2, 8'h80, 8'hFF, 8'h00, 8'h80);
        run8("w8_div_neg", 3'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD);
        run8("w8_divu_zero", 3'd3, 8'h64, 8'h00, 8'h64, 8'hFF);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid/busy", busy, 0);
        check_eq("rst_mid/done", done, 0);
        check_eq("rst_mid/hi", hi, 0);
        check_eq("rst_mid/lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_after/busy", busy, 0);
        check_eq("rst_after/hi", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
